// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: 2-bit BHT hint for fetch, resolves EX-stage control flow,
// and sequences the redirect handshake plus pipeline flush/drain on a mispredict.
module branch_redirect_ctrl #(
  parameter int ENTRIES      = 16,
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pred_next,
  output logic             ex_stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  logic [1:0]       r_state;
  logic [DRN_W-1:0] r_drain_cnt;
  logic [31:0]      r_redirect_pc;
  logic [1:0]       r_bht [ENTRIES];
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic             w_idle;
  logic             w_accept;
  logic             w_bht_upd;
  logic             w_mispredict;
  logic [31:0]      w_actual_next;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_bht_cur;
  logic             w_unused;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_unused = &{1'b0, if_pc[31:IDX_W+2], if_pc[1:0]};

  assign w_idle        = (r_state == ST_IDLE);
  assign w_accept      = ex_valid && w_idle && (ex_is_branch || ex_is_jump);
  // A branch+jump encoding is treated as a jump, so it never trains the BHT.
  assign w_bht_upd     = w_accept && ex_is_branch && !ex_is_jump;
  assign w_actual_next = ex_taken ? ex_target : (ex_pc + 32'd4);
  assign w_mispredict  = w_accept && (w_actual_next != ex_pred_next);
  assign w_bht_cur     = r_bht[w_ex_idx];

  assign if_pred_taken    = r_bht[w_if_idx][1];
  assign ex_stall         = !w_idle;
  assign flush            = !w_idle;
  assign redirect_valid   = (r_state == ST_REDIRECT);
  assign redirect_pc      = r_redirect_pc;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mispredict) begin
            r_redirect_pc <= w_actual_next;
            r_state       <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            if (DRAIN_CYCLES > 0) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRN_W'(DRAIN_CYCLES);
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt <= DRN_W'(1)) r_state <= ST_IDLE;
          else                         r_drain_cnt <= r_drain_cnt - DRN_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the BHT is reset entry by entry because the weakly-not-taken start state is architectural.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (w_bht_upd) begin
      if (ex_taken && (w_bht_cur != 2'b11))       r_bht[w_ex_idx] <= w_bht_cur + 2'd1;
      else if (!ex_taken && (w_bht_cur != 2'b00)) r_bht[w_ex_idx] <= w_bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_bht_upd && (r_branch_count != '1))
        r_branch_count <= r_branch_count + CNT_W'(1);
      if (w_mispredict && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a default instance (1 drain cycle) and a
// DRAIN_CYCLES=0 / CNT_W=2 instance share the same stimulus.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_next;
  logic        redirect_ready;

  logic        if_pred_taken, ex_stall, redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic        d0_if_pred_taken, d0_ex_stall, d0_redirect_valid, d0_flush;
  logic [31:0] d0_redirect_pc;
  logic [1:0]  d0_branch_count, d0_mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ENTRIES(16), .DRAIN_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_next(ex_pred_next),
    .ex_stall(ex_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_redirect_ctrl #(.ENTRIES(16), .DRAIN_CYCLES(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(d0_if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_next(ex_pred_next),
    .ex_stall(d0_ex_stall), .redirect_valid(d0_redirect_valid), .redirect_pc(d0_redirect_pc),
    .redirect_ready(redirect_ready), .flush(d0_flush),
    .branch_count(d0_branch_count), .mispredict_count(d0_mispredict_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic br, input logic jmp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pn);
    ex_valid     = 1'b1;
    ex_is_branch = br;
    ex_is_jump   = jmp;
    ex_taken     = tk;
    ex_pc        = pc;
    ex_target    = tgt;
    ex_pred_next = pn;
  endtask

  typedef struct {
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] pn;
    logic        hint_before;
    logic        hint_after;
    logic [15:0] br_cnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Correctly predicted (or not accepted) vectors applied back to back while IDLE.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100,      32'h0,  32'h104,  1'b0, 1'b0, 16'd1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h200,      32'h3000, 32'h3000, 1'b0, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h10,       32'h40, 32'h40,   1'b0, 1'b1, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h10,       32'h40, 32'h40,   1'b1, 1'b1, 16'd3};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h10,       32'h40, 32'h40,   1'b1, 1'b1, 16'd4};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h10,       32'h40, 32'h14,   1'b1, 1'b1, 16'd5};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h10,       32'h40, 32'h14,   1'b1, 1'b0, 16'd6};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h40, 32'h0,    1'b0, 1'b0, 16'd7};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 32'h10,       32'h40, 32'h1234, 1'b0, 1'b0, 16'd7};

    rst = 1'b1; if_pc = '0; redirect_ready = 1'b0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_next = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check($sformatf("reset_hint_%0d", i), {31'd0, if_pred_taken}, 32'd0);
    end
    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_stall", {31'd0, ex_stall}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_branch_count", {16'd0, branch_count}, 32'd0);
    check("reset_mispredict_count", {16'd0, mispredict_count}, 32'd0);
    tick();

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      drive_ex(vecs[v].br, vecs[v].jmp, vecs[v].tk, vecs[v].pc, vecs[v].tgt, vecs[v].pn);
      if_pc = vecs[v].pc;
      #1;
      check($sformatf("vec%0d_hint_before", v), {31'd0, if_pred_taken}, {31'd0, vecs[v].hint_before});
      check($sformatf("vec%0d_stall_before", v), {31'd0, ex_stall}, 32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_hint_after", v), {31'd0, if_pred_taken}, {31'd0, vecs[v].hint_after});
      check($sformatf("vec%0d_redirect", v), {31'd0, redirect_valid}, 32'd0);
      check($sformatf("vec%0d_stall_after", v), {31'd0, ex_stall}, 32'd0);
      check($sformatf("vec%0d_branch_count", v), {16'd0, branch_count}, {16'd0, vecs[v].br_cnt});
      check($sformatf("vec%0d_mispredict_count", v), {16'd0, mispredict_count}, 32'd0);
    end
    check("d0_branch_count_saturated", {30'd0, d0_branch_count}, 32'd3);

    // Taken branch mispredict with fetch holding off the redirect
    drive_ex(1'b1, 1'b0, 1'b1, 32'h104, 32'h80, 32'h108);
    redirect_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mp_redirect_valid_%0d", k), {31'd0, redirect_valid}, 32'd1);
      check($sformatf("mp_redirect_pc_%0d", k), redirect_pc, 32'h80);
      check($sformatf("mp_flush_%0d", k), {31'd0, flush}, 32'd1);
      check($sformatf("mp_stall_%0d", k), {31'd0, ex_stall}, 32'd1);
      if (k == 1) drive_ex(1'b1, 1'b0, 1'b0, 32'h104, 32'h999, 32'h999);
      if (k == 3) redirect_ready = 1'b1;
      tick();
      ex_valid = 1'b0;
    end
    check("d0_redirect_pc", d0_redirect_pc, 32'h80);
    redirect_ready = 1'b0;
    check("drain_flush", {31'd0, flush}, 32'd1);
    check("drain_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("drain_stall", {31'd0, ex_stall}, 32'd1);
    check("d0_idle_flush", {31'd0, d0_flush}, 32'd0);
    check("d0_idle_stall", {31'd0, d0_ex_stall}, 32'd0);
    tick();
    check("post_drain_flush", {31'd0, flush}, 32'd0);
    check("post_drain_stall", {31'd0, ex_stall}, 32'd0);
    check("mp_mispredict_count", {16'd0, mispredict_count}, 32'd1);
    check("mp_branch_count", {16'd0, branch_count}, 32'd8);
    check("d0_mispredict_count", {30'd0, d0_mispredict_count}, 32'd1);
    if_pc = 32'h104;
    #1;
    check("mp_hint_0x104", {31'd0, if_pred_taken}, 32'd1);
    tick();

    // JALR mispredict, handshake on the first redirect cycle
    drive_ex(1'b0, 1'b1, 1'b1, 32'h200, 32'h3000, 32'h204);
    tick();
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    check("jalr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("jalr_redirect_pc", redirect_pc, 32'h3000);
    check("jalr_branch_count", {16'd0, branch_count}, 32'd8);
    check("jalr_mispredict_count", {16'd0, mispredict_count}, 32'd2);
    tick();
    redirect_ready = 1'b0;
    check("jalr_drain_flush", {31'd0, flush}, 32'd1);
    tick();
    check("jalr_idle_flush", {31'd0, flush}, 32'd0);
    if_pc = 32'h200;
    #1;
    check("jalr_hint_unchanged", {31'd0, if_pred_taken}, 32'd0);

    // Reset aborts a pending redirect
    drive_ex(1'b1, 1'b0, 1'b1, 32'h20, 32'h500, 32'h24);
    tick();
    ex_valid = 1'b0;
    check("pre_reset_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("pre_reset_redirect_pc", redirect_pc, 32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("abort_flush", {31'd0, flush}, 32'd0);
    check("abort_stall", {31'd0, ex_stall}, 32'd0);
    check("abort_redirect_pc", redirect_pc, 32'd0);
    check("abort_branch_count", {16'd0, branch_count}, 32'd0);
    check("abort_mispredict_count", {16'd0, mispredict_count}, 32'd0);
    if_pc = 32'h104;
    #1;
    check("abort_hint_0x104", {31'd0, if_pred_taken}, 32'd0);
    if_pc = 32'h20;
    #1;
    check("abort_hint_0x20", {31'd0, if_pred_taken}, 32'd0);
    check("abort_d0_flush", {31'd0, d0_flush}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow resolution between fetch and execute. Holds a direct-mapped 2-bit branch history table (BHT) that fetch reads for a taken/not-taken hint. Takes resolved branch/jump outcomes from the EX-stage branch decision logic and compares the actual next PC against the next PC fetch predicted. On a mismatch it drives a redirect handshake to fetch and a pipeline flush.

Parameters:
ENTRIES, 16, BHT entries; power of two, >= 2; index = pc[log2(ENTRIES)+1:2]
DRAIN_CYCLES, 1, extra flush cycles after the redirect handshake; 0 allowed
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  32  fetch PC for the BHT lookup
if_pred_taken  out  1  combinational BHT MSB at index(if_pc)
ex_valid  in  1  EX holds a resolved control-flow instruction
ex_is_branch  in  1  conditional branch
ex_is_jump  in  1  JAL/JALR
ex_taken  in  1  resolved outcome (jumps drive 1)
ex_pc  in  32  PC of the EX instruction
ex_target  in  32  resolved taken target
ex_pred_next  in  32  next PC fetch used after ex_pc
ex_stall  out  1  EX must hold; equals busy (state != IDLE)
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  corrected PC
redirect_ready  in  1  fetch accepts the redirect
flush  out  1  kill all instructions younger than the resolved one
branch_count  out  CNT_W  accepted conditional branches
mispredict_count  out  CNT_W  accepted redirects

Behaviour:
- Reset (sync, rst high at clk edge): state=IDLE, all BHT entries=2'b01, redirect_valid=0, flush=0, redirect_pc=0, both counters=0. Reset mid-REDIRECT or mid-DRAIN aborts to IDLE; outputs are low from the following cycle.
- Accept: ex_valid && state==IDLE && (ex_is_branch || ex_is_jump). When busy, ex_valid is ignored: no BHT update, no count, no redirect.
- actual_next = ex_taken ? ex_target : ex_pc+32'd4 (mod 2^32). mispredict = accept && (actual_next != ex_pred_next).
- BHT update on accept with ex_is_branch only (not jumps): 2-bit saturating counter, +1 if taken (saturates at 11), -1 if not (saturates at 00). Takes effect at the next edge. A same-cycle if_pc read of the same index returns the old value.
- branch_count += 1 on accept with ex_is_branch. mispredict_count += 1 on mispredict. Both saturate at all-ones.
- FSM:
  - IDLE: on mispredict, latch redirect_pc=actual_next and go to REDIRECT; otherwise stay.
  - REDIRECT: redirect_valid=1, flush=1. redirect_pc stays stable until the handshake (redirect_valid && redirect_ready). On handshake, go to DRAIN if DRAIN_CYCLES>0, else IDLE.
  - DRAIN: flush=1, redirect_valid=0. Down-counter loaded with DRAIN_CYCLES; return to IDLE after exactly DRAIN_CYCLES cycles.
- Latency: mispredict accepted in cycle N gives redirect_valid=1 in N+1. A correct prediction produces no redirect and no stall.
- ex_stall is high in REDIRECT and DRAIN. Back-to-back accepts are allowed only while IDLE with no mispredict.
- ex_is_branch and ex_is_jump both high is illegal; treat it as a jump (no BHT update).

Test Plan:
- rst high for 2 cycles, then low -> if_pred_taken=0 for if_pc=0x0..0x3C; redirect_valid=0, flush=0, counters=0.
- accept branch ex_pc=0x100, ex_taken=0, ex_pred_next=0x104 -> no redirect, ex_stall stays 0; branch_count=1; BHT[0] goes 01->00.
- accept branch ex_pc=0x104, ex_taken=1, ex_target=0x80, ex_pred_next=0x108; hold redirect_ready=0 for 3 cycles -> from N+1: redirect_valid=1, redirect_pc=0x80, flush=1, all stable for 4 cycles. After the handshake: 1 DRAIN cycle with flush=1, then IDLE. mispredict_count=1; if_pc=0x104 -> if_pred_taken=1.
- JALR ex_pc=0x200, ex_target=0x3000, ex_pred_next=0x3000 -> no redirect, BHT unchanged, branch_count unchanged. Repeat with ex_pred_next=0x204 -> redirect_pc=0x3000.
- ex_valid pulsed (mispredicting) during REDIRECT -> ignored: mispredict_count unchanged, redirect_pc unchanged. Assert rst during REDIRECT -> redirect_valid=0 and flush=0 on the next cycle; BHT back to 01.
- three taken updates at ex_pc=0x10 -> counter 01->10->11->11. Then two not-taken -> 01, and if_pc=0x10 gives if_pred_taken=0. Repeat with DRAIN_CYCLES=0 -> IDLE directly after the handshake.
